// File: rtl/conv3x3_bin.sv
// Sequential 3x3 binary-image convolution: one thresholded window sum per cycle into a 6x6 map
// held under valid/ready. Optional abort input is enabled with `define CONV3X3_ABORT_EN.
module conv3x3_bin #(
  parameter logic signed [7:0] THRESHOLD = 8'sd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] image_in,
  input  logic [35:0] kernel_in,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef CONV3X3_ABORT_EN
  input  logic        abort,
`endif
  output logic [35:0] feature_map_out
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [63:0] image_q, image_d;
  logic [35:0] kernel_q, kernel_d;
  logic [35:0] fmap_q, fmap_d;
  logic [2:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        abort_w;

`ifdef CONV3X3_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  logic signed [7:0] win_sum;
  logic [5:0]        pix_idx;
  logic [3:0]        wt;
  logic [5:0]        pos_idx;
  logic              pos_bit;

  // Window at (row_q, col_q); row+kr and col+kc never exceed 7, so 3-bit sums cannot wrap.
  always_comb begin
    win_sum = '0;
    pix_idx = '0;
    wt      = '0;
    for (int kr = 0; kr < 3; kr++) begin
      for (int kc = 0; kc < 3; kc++) begin
        pix_idx = {row_q + 3'(kr), col_q + 3'(kc)};
        wt      = kernel_q[4*(kr*3+kc) +: 4];
        if (image_q[pix_idx]) begin
          win_sum = win_sum + $signed({{4{wt[3]}}, wt});
        end
      end
    end
  end

  assign pos_idx = ({3'b000, row_q} * 6'd6) + {3'b000, col_q};
  assign pos_bit = (win_sum > THRESHOLD);

  always_comb begin
    state_d  = state_q;
    image_d  = image_q;
    kernel_d = kernel_q;
    fmap_d   = fmap_q;
    row_d    = row_q;
    col_d    = col_q;
    busy_d   = busy_q;
    valid_d  = valid_q;

    unique case (state_q)
      StIdle: begin
        if (start && !abort_w) begin
          image_d  = image_in;
          kernel_d = kernel_in;
          fmap_d   = '0;
          row_d    = '0;
          col_d    = '0;
          busy_d   = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        fmap_d[pos_idx] = pos_bit;
        if (col_q == 3'd5) begin
          col_d = '0;
          if (row_q == 3'd5) begin
            valid_d = 1'b1;
            state_d = StDone;
          end else begin
            row_d = row_q + 3'd1;
          end
        end else begin
          col_d = col_q + 3'd1;
        end
      end
      StDone: begin
        // start arriving with the handshake is deliberately dropped.
        if (out_ready) begin
          busy_d  = 1'b0;
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort wins over both the pipeline advance and the output handshake.
    if (abort_w && (state_q != StIdle)) begin
      state_d = StIdle;
      fmap_d  = '0;
      row_d   = '0;
      col_d   = '0;
      busy_d  = 1'b0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      image_q  <= '0;
      kernel_q <= '0;
      fmap_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      image_q  <= image_d;
      kernel_q <= kernel_d;
      fmap_q   <= fmap_d;
      row_q    <= row_d;
      col_q    <= col_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign busy            = busy_q;
  assign out_valid       = valid_q;
  assign feature_map_out = fmap_q;

  a_valid_implies_busy: assert property (@(posedge clk) disable iff (!rst_n)
    valid_q |-> busy_q);
  a_map_stable_in_done: assert property (@(posedge clk) disable iff (!rst_n)
    (valid_q && !out_ready && !abort_w) |=> (valid_q && $stable(fmap_q)));
  a_counters_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    (row_q <= 3'd5) && (col_q <= 3'd5));

endmodule

// File: doc/conv3x3_bin.md
# conv3x3_bin

Sequential 3x3 convolution engine feeding the 2x2 max-pool stage. Takes an 8x8 binary image and a 3x3 kernel of signed 4-bit weights. Computes the 36 valid-window sums, one output position per cycle, and thresholds each sum to 1 bit. Presents the resulting 6x6 binary feature map as a 36-bit row-major word, held under a valid/ready handshake until the pooling side accepts it.

## Interface
- THRESHOLD, 0: signed 8-bit compare value; output bit = (sum > THRESHOLD).
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new convolution; accepted only in IDLE.
- image_in  input  64  pixel (r,c) at bit r*8+c, r,c in 0..7.
- kernel_in  input  36  weight k=kr*3+kc at bits [4k+3:4k], two's complement.
- busy  output  1  high in RUN and DONE.
- out_valid  output  1  high in DONE; feature map complete and stable.
- out_ready  input  1  consumer accepts feature map when high with out_valid.
- feature_map_out  output  36  position (i,j) at bit i*6+j, i,j in 0..5.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch image_in and kernel_in into internal registers.
  - Clear feature_map_out to 0 and row/col counters to 0.
  - Go to RUN.
- RUN, one position per cycle at (row,col):
  - sum = Σ w[kr*3+kc] over kr,kc in 0..2 where pixel(row+kr, col+kc)=1.
  - Write (sum > THRESHOLD) to bit row*6+col.
  - Advance col; on col=5, wrap col to 0 and increment row.
  - After writing (5,5), go to DONE.
- Arithmetic:
  - Weights are sign-extended to an 8-bit signed accumulator.
  - Range is -72..63; no overflow is possible.
  - Compare against THRESHOLD is signed.
- DONE:
  - Hold feature_map_out and out_valid=1.
  - On out_ready=1, go to IDLE.
- Rules:
  - start is ignored in RUN and DONE, including when it arrives in the same cycle as the DONE→IDLE handshake. It must be re-presented in IDLE.
  - Input changes after acceptance do not affect the run, since inputs are latched.
  - Reset at any point forces IDLE. Reset mid-RUN discards partial results.
- Reset values: busy=0, out_valid=0, feature_map_out=0. Internal registers and counters also reset to 0.

## Timing
- Edge E0 samples start=1 in IDLE.
- Edges E1..E36 write positions (0,0)..(5,5) in row-major order.
- out_valid and busy are registered outputs:
  - out_valid rises after E36, i.e. 36 cycles after acceptance.
  - busy rises after E0.
- Handshake completes on the edge where out_valid=1 and out_ready=1. After that edge, out_valid=0 and busy=0.
- Earliest next start acceptance is the following edge. Minimum throughput is one map per 38 cycles.
- feature_map_out is unchanged while out_valid=1. Intermediate bits are visible during RUN but are not meaningful.

## Configuration
- CONV3X3_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort=1 in RUN or DONE returns to IDLE on the next edge and clears feature_map_out.
  - out_valid is never raised for an aborted run.
  - abort has priority over out_ready.
  - abort in IDLE has priority over start: start is not accepted.
- CONV3X3_ABORT_EN undefined: no abort port; a run always completes to DONE.

## Test plan
- All-ones image, all weights +1, THRESHOLD=0 -> every sum 9, feature_map_out=36'hF_FFFF_FFFF, out_valid rises 36 cycles after start edge.
- Single pixel at (3,3), center weight +1, others 0 -> only bit 14 set (position 2,2), feature_map_out=36'h0_0000_4000.
- All-ones image, all weights +7 -> sum 63:
  - THRESHOLD=62 gives all bits 1; THRESHOLD=63 gives all 0.
  - All weights -8 (sum -72) with THRESHOLD=-73 gives all 1.
- Backpressure: hold out_ready=0 for 10 cycles with start pulsing -> output and out_valid stable, no restart. Then assert out_ready with start=1 in the same cycle -> IDLE, busy=0, no new run.
- Assert rst_n=0 at position 20 of a run -> outputs 0 immediately, IDLE. A fresh start then produces a correct map in 36 cycles.
- With CONV3X3_ABORT_EN: abort at position 10 -> IDLE next edge, out_valid never rises, feature_map_out=0. Next start completes normally.
